// File: rtl/fp_minmax_reduce.sv
// Streaming IEEE-754 min/max reduction with RISC-V FMIN/FMAX semantics.
// Accepts one element per cycle and reports the winner, its index and NV.
module fp_minmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IDX_W = 8,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [IDX_W-1:0] out_index,
  output logic [4:0]       out_flags,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             nv_q, nv_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_result_q, out_result_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             take;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  // Returns 1 when the incoming element replaces the accumulator.
  function automatic logic take_elem(input logic [W-1:0] acc,
                                     input logic [W-1:0] elem,
                                     input logic         op_max);
    logic gt, lt;
    gt = elem[W-2:0] > acc[W-2:0];
    lt = elem[W-2:0] < acc[W-2:0];
    if (is_nan(elem))               return 1'b0;
    else if (is_nan(acc))           return 1'b1;
    else if (elem[W-1] != acc[W-1]) return op_max ? !elem[W-1] : elem[W-1];
    else                            return (elem[W-1] ^ op_max) ? gt : lt;
  endfunction

  function automatic logic [W-1:0] canon(input logic [W-1:0] x);
    logic [W-1:0] c;
    c              = '0;
    c[W-2:MAN_W]   = '1;
    c[MAN_W-1]     = 1'b1;
    return is_nan(x) ? c : x;
  endfunction

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign take     = take_elem(acc_q, in_data, op_q);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    nv_d         = nv_q;
    ovf_d        = ovf_q;
    full_d       = full_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_index_d  = out_index_q;
    out_flags_d  = out_flags_q;
    out_ovf_d    = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d  = in_data;
          idx_d  = '0;
          cnt_d  = IDX_W'(1);
          op_d   = in_op;
          nv_d   = is_snan(in_data);
          ovf_d  = 1'b0;
          full_d = 1'b0;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d  = take ? in_data : acc_q;
          idx_d  = take ? cnt_q : idx_q;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + IDX_W'(1);
          // Once the last representable index is used, any further element overflows.
          full_d = full_q || (cnt_q == CNT_MAX);
          ovf_d  = ovf_q || full_q;
          nv_d   = nv_q || is_snan(in_data);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (in_last) begin
        state_d      = DONE;
        out_valid_d  = 1'b1;
        out_result_d = canon(acc_d);
        out_index_d  = is_nan(acc_d) ? '0 : idx_d;
        out_flags_d  = {nv_d, 4'b0000};
        out_ovf_d    = ovf_d;
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      nv_q         <= 1'b0;
      ovf_q        <= 1'b0;
      full_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_index_q  <= '0;
      out_flags_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      nv_q         <= nv_d;
      ovf_q        <= ovf_d;
      full_q       <= full_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_index_q  <= out_index_d;
      out_flags_q  <= out_flags_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  // Accumulator datapath carries no reset; IDLE reloads it on the first element.
  always_ff @(posedge clock) begin
    acc_q <= acc_d;
    idx_q <= idx_d;
    cnt_q <= cnt_d;
    op_q  <= op_d;
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_index  = out_index_q;
  assign out_flags  = out_flags_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Bench for fp_minmax_reduce: directed vectors plus random vectors against a total-order model.
// Two instances (IDX_W=8 and IDX_W=2) share the same stimulus.
module tb_fp_minmax_reduce;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_last, in_op, out_ready;
  logic [31:0] in_data;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_result_a;
  logic [7:0]  out_index_a;
  logic [4:0]  out_flags_a;

  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [31:0] out_result_b;
  logic [1:0]  out_index_b;
  logic [4:0]  out_flags_b;

  int n_vec = 0;
  int n_bad = 0;

  fp_minmax_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(8)) dut_a (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_result(out_result_a),
    .out_index(out_index_a), .out_flags(out_flags_a), .out_ovf(out_ovf_a)
  );

  fp_minmax_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(2)) dut_b (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_result(out_result_b),
    .out_index(out_index_b), .out_flags(out_flags_b), .out_ovf(out_ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit f_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // Total-order key over non-NaN values: -0 sorts just below +0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? (-m - 1) : m;
  endfunction

  function automatic void model(input logic [31:0] v[$], input bit op, input int idx_w,
                                output logic [31:0] res, output logic [31:0] idx,
                                output logic [31:0] flg, output logic [31:0] ovf);
    int     best = -1;
    bit     nv = 1'b0;
    longint bk = 0;
    int     maxi;
    logic [31:0] e;
    foreach (v[i]) begin
      e = v[i];
      if (f_nan(e)) begin
        if (!e[22]) nv = 1'b1;
      end else if (best < 0 || (op ? (key(e) > bk) : (key(e) < bk))) begin
        best = i;
        bk   = key(e);
      end
    end
    maxi = (1 << idx_w) - 1;
    if (best < 0) begin
      res = 32'h7FC00000;
      idx = 0;
    end else begin
      res = v[best];
      idx = (best > maxi) ? maxi : best;
    end
    flg = {27'b0, nv, 4'b0};
    ovf = (v.size() > (1 << idx_w)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] rnd_elem();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {r[31], 31'h0};
      1:       return {r[31], 8'hFF, 23'h0};
      2:       return {r[31], 8'hFF, 1'b1, r[21:0]};
      3:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      default: return {r[31], 8'd126 + 8'($urandom_range(0, 2)), 21'h0, r[1:0]};
    endcase
  endfunction

  // Drives one vector at negedges, checks the result, holds it for 'hold' cycles, then consumes it.
  task automatic run_vec(input logic [31:0] v[$], input bit op, input int hold, input bit rnd);
    logic [31:0] ra, ia, fa, oa, rb, ib, fb, ob;
    model(v, op, 8, ra, ia, fa, oa);
    model(v, op, 2, rb, ib, fb, ob);
    for (int i = 0; i < v.size(); i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
      end
      check("in_ready_a_acc", in_ready_a, 1);
      check("in_ready_b_acc", in_ready_b, 1);
      check("out_valid_early", out_valid_a, 0);
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = (i == v.size() - 1);
      in_op    = (i == 0 || !rnd) ? op : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'($urandom_range(0, 1));
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
    check("out_valid_a", out_valid_a, 1);
    check("out_valid_b", out_valid_b, 1);
    check("result_a", out_result_a, ra);
    check("index_a", out_index_a, ia);
    check("flags_a", out_flags_a, fa);
    check("ovf_a", out_ovf_a, oa);
    check("result_b", out_result_b, rb);
    check("index_b", out_index_b, ib);
    check("flags_b", out_flags_b, fb);
    check("ovf_b", out_ovf_b, ob);
    check("in_ready_done", in_ready_a, 0);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", out_valid_a, 1);
      check("hold_result", out_result_a, ra);
      check("hold_index", out_index_a, ia);
      check("hold_flags", out_flags_a, fa);
      check("hold_in_ready", in_ready_a, 0);
      check("hold_in_ready_b", in_ready_b, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_last   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consumed_valid", out_valid_a, 0);
    check("consumed_in_ready", in_ready_a, 1);
  endtask

  logic [31:0] q[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_op     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_result", out_result_a, 0);
    check("rst_out_index", out_index_a, 0);
    check("rst_out_flags", out_flags_a, 0);
    check("rst_out_ovf", out_ovf_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    q = {32'h3F800000, 32'hC0000000, 32'h40600000};  run_vec(q, 1'b1, 0, 1'b0);
    q = {32'h00000000, 32'h80000000};                 run_vec(q, 1'b0, 0, 1'b0);
    q = {32'h00000000, 32'h80000000};                 run_vec(q, 1'b1, 0, 1'b0);
    q = {32'h40000000, 32'h40000000};                 run_vec(q, 1'b1, 0, 1'b0);
    q = {32'h7F800001, 32'h7FC00000, 32'hBF800000};  run_vec(q, 1'b1, 0, 1'b0);
    q = {32'h7FC00001, 32'hFFC00000};                 run_vec(q, 1'b0, 0, 1'b0);
    q = {32'hC1000000, 32'h3F000000};                 run_vec(q, 1'b0, 3, 1'b0);
    q = {32'h7FA00000};                               run_vec(q, 1'b1, 0, 1'b0);
    q = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    run_vec(q, 1'b1, 0, 1'b0);

    // Abort a partial vector with an asynchronous reset.
    in_valid = 1'b1; in_last = 1'b0; in_op = 1'b1; in_data = 32'h3F800000;
    @(negedge clk);
    in_data = 32'h7F000000;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready_a, 1);
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_result", out_result_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = {32'h41200000};                               run_vec(q, 1'b0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      q = {};
      for (int j = 0; j < int'($urandom_range(1, 7)); j++) q.push_back(rnd_elem());
      run_vec(q, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
